// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: bus width defaults, FSM states and op encoding.
package mem_pkg;

    localparam int MEM_DATA_W = 16;
    localparam int MEM_ADDR_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the control unit (master) and the memory responder (slave).
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              wdone;
    logic              busy;
    logic              err;

    modport master (
        output read, write, addr, wdata,
        input  rdata, rvalid, wdone, busy, err
    );

    modport slave (
        input  read, write, addr, wdata,
        output rdata, rvalid, wdone, busy, err
    );

endinterface

// File: rtl/mem_resp_ram.sv
// Single-port synchronous RAM with registered read data (read-before-write).
module mem_resp_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: the storage array and its read register carry no reset, so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= din;
        end
        dout <= mem_q[idx];
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency single-word memory responder. Defining MEM_BOUNDS_CHECK_EN flags captured
// addresses >= DEPTH via err instead of aliasing them. DEPTH: power of two; LATENCY: 1..7.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W  = MEM_DATA_W,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int              IDX_W    = $clog2(DEPTH);
    localparam int              CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              accept;
    logic              oob;
    logic              rvalid, wdone, err, busy;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_idx;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] rd_value;

    assign accept = (state_q == S_IDLE) && (bus.read || bus.write);
    assign oob    = BOUNDS_EN && ({1'b0, addr_q} >= (ADDR_W + 1)'(DEPTH));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (rvalid) begin
                rdata_q <= rd_value;
            end
        end
    end

    // Capture registers are only meaningful after an accept, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= bus.write ? OP_WR : OP_RD;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, which rules out latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        rvalid   = (state_q == S_RESP) && (op_q == OP_RD);
        wdone    = (state_q == S_RESP) && (op_q == OP_WR);
        err      = (state_q == S_RESP) && oob;
        ram_we   = wdone && !oob && !reset;
        rd_value = oob ? '0 : ram_dout;
        // In IDLE the RAM is addressed straight from the bus so a LATENCY of 1 still has data in RESP.
        ram_idx  = (state_q == S_IDLE) ? bus.addr[IDX_W-1:0] : addr_q[IDX_W-1:0];
    end

    mem_resp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .idx  (ram_idx),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    assign bus.rdata  = rvalid ? rd_value : rdata_q;
    assign bus.rvalid = rvalid;
    assign bus.wdone  = wdone;
    assign bus.busy   = busy;
    assign bus.err    = err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one LATENCY=2/DEPTH=256 instance and one LATENCY=1/DEPTH=128.
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef struct {
        bit          is_wr;
        logic [15:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    mem_responder_if #(.DATA_W(16), .ADDR_W(8)) a_if ();
    mem_responder_if #(.DATA_W(16), .ADDR_W(8)) b_if ();

    mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .LATENCY(2)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (a_if.slave)
    );

    mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .LATENCY(1)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b_if.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every completion pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (a_if.rvalid || a_if.wdone) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_pulse", {a_if.wdone, a_if.rvalid}, 32'd0);
            end else begin
                e = q_a.pop_front();
                check("a_kind", {a_if.wdone, a_if.rvalid}, e.is_wr ? 32'd2 : 32'd1);
                if (!e.is_wr) check("a_rdata", a_if.rdata, e.data);
                check("a_err", a_if.err, e.err);
                check("a_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_if.rvalid || b_if.wdone) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_pulse", {b_if.wdone, b_if.rvalid}, 32'd0);
            end else begin
                e = q_b.pop_front();
                check("b_kind", {b_if.wdone, b_if.rvalid}, e.is_wr ? 32'd2 : 32'd1);
                if (!e.is_wr) check("b_rdata", b_if.rdata, e.data);
                check("b_err", b_if.err, e.err);
                check("b_cycle", cyc, e.cyc);
            end
        end
    end

    // One-cycle request; addr/wdata are scrambled afterwards to prove they were captured.
    task automatic issue(input bit sel, input bit rd, input bit wr, input logic [7:0] addr,
                         input logic [15:0] wd, input logic [15:0] exp_data, input bit exp_err);
        exp_t e;
        @(negedge clk);
        e.is_wr = wr;
        e.data  = exp_data;
        e.err   = exp_err;
        e.cyc   = cyc + (sel ? 1 : 2);
        if (!sel) begin
            a_if.read = rd; a_if.write = wr; a_if.addr = addr; a_if.wdata = wd;
            q_a.push_back(e);
        end else begin
            b_if.read = rd; b_if.write = wr; b_if.addr = addr; b_if.wdata = wd;
            q_b.push_back(e);
        end
        @(negedge clk);
        if (!sel) begin
            a_if.read = 1'b0; a_if.write = 1'b0; a_if.addr = ~addr; a_if.wdata = ~wd;
        end else begin
            b_if.read = 1'b0; b_if.write = 1'b0; b_if.addr = ~addr; b_if.wdata = ~wd;
        end
    endtask

    task automatic check_idle_a(input string tag, input logic [15:0] exp_rdata);
        check({tag, "_busy"}, a_if.busy, 32'd0);
        check({tag, "_rvalid"}, a_if.rvalid, 32'd0);
        check({tag, "_wdone"}, a_if.wdone, 32'd0);
        check({tag, "_err"}, a_if.err, 32'd0);
        check({tag, "_rdata"}, a_if.rdata, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        a_if.read = 1'b0; a_if.write = 1'b0; a_if.addr = '0; a_if.wdata = '0;
        b_if.read = 1'b0; b_if.write = 1'b0; b_if.addr = '0; b_if.wdata = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_a("reset_a", 16'h0000);
        check("reset_b_busy", b_if.busy, 32'd0);
        check("reset_b_rdata", b_if.rdata, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Write 0xBEEF @0x12 with a read strobe while busy, then read back.
        begin
            exp_t e;
            @(negedge clk);
            e.is_wr = 1'b1; e.data = 16'h0; e.err = 1'b0; e.cyc = cyc + 2;
            q_a.push_back(e);
            a_if.write = 1'b1; a_if.addr = 8'h12; a_if.wdata = 16'hBEEF;
            check("t0_busy", a_if.busy, 32'd0);
            @(negedge clk);
            a_if.write = 1'b0; a_if.read = 1'b1; a_if.addr = 8'h12; a_if.wdata = 16'h0000;
            check("t1_busy", a_if.busy, 32'd1);
            @(negedge clk);
            a_if.read = 1'b0;
            check("t2_busy", a_if.busy, 32'd1);
            @(negedge clk);
            check("t3_busy", a_if.busy, 32'd0);
            e.is_wr = 1'b0; e.data = 16'hBEEF; e.err = 1'b0; e.cyc = cyc + 2;
            q_a.push_back(e);
            a_if.read = 1'b1; a_if.addr = 8'h12;
            @(negedge clk);
            a_if.read = 1'b0; a_if.addr = 8'hFF;
            check("t4_busy", a_if.busy, 32'd1);
            @(negedge clk);
            check("t5_busy", a_if.busy, 32'd1);
            @(negedge clk);
            check("t6_busy", a_if.busy, 32'd0);
            check("t6_rdata_hold", a_if.rdata, 32'hBEEF);
        end

        // Simultaneous read+write behaves as a write; rdata untouched by it.
        issue(1'b0, 1'b1, 1'b1, 8'h05, 16'h1234, 16'h0, 1'b0);
        @(negedge clk);
        check("rw_rdata_hold", a_if.rdata, 32'hBEEF);
        issue(1'b0, 1'b1, 1'b0, 8'h05, 16'h0, 16'h1234, 1'b0);
        @(negedge clk);

        // Highest address of the RAM.
        issue(1'b0, 1'b0, 1'b1, 8'hFF, 16'hA5A5, 16'h0, 1'b0);
        @(negedge clk);
        issue(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0, 16'hA5A5, 1'b0);
        @(negedge clk);

        // Reset in the middle of a write aborts it.
        issue(1'b0, 1'b0, 1'b1, 8'h30, 16'h7777, 16'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a_if.write = 1'b1; a_if.addr = 8'h30; a_if.wdata = 16'h00AA;
        @(negedge clk);
        a_if.write = 1'b0;
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check_idle_a("midrst", 16'h0000);
        issue(1'b0, 1'b1, 1'b0, 8'h30, 16'h0, 16'h7777, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // LATENCY=1, back-to-back requests, and the 0x80 boundary of a 128-word RAM.
        issue(1'b1, 1'b0, 1'b1, 8'h00, 16'h0011, 16'h0, 1'b0);
        issue(1'b1, 1'b1, 1'b0, 8'h00, 16'h0, 16'h0011, 1'b0);
        issue(1'b1, 1'b0, 1'b1, 8'h80, 16'h5555, 16'h0, BOUNDS);
        issue(1'b1, 1'b1, 1'b0, 8'h00, 16'h0, BOUNDS ? 16'h0011 : 16'h5555, 1'b0);
        issue(1'b1, 1'b1, 1'b0, 8'h80, 16'h0, BOUNDS ? 16'h0000 : 16'h5555, BOUNDS);
        @(negedge clk);
        check("b_idle_busy", b_if.busy, 32'd0);
        check("b_idle_err", b_if.err, 32'd0);

        repeat (4) @(negedge clk);
        check("a_queue_drained", q_a.size(), 32'd0);
        check("b_queue_drained", q_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
